rf_wb_queue: RTL and testbench

Writeback queue and arbiter driving the register file's single write port. Accepts register-write results from the memory-load path and the ALU path over valid/ready handshakes, buffers them in order, and retires exactly one write per clock onto the register file's write-address/write-data/write-enable inputs. While a write is queued, its value is forwarded to two read-address probes, so readers never see a stale register.

---
 rtl/mips_pkg.sv | 10 +
 rtl/rf_wb_queue_if.sv | 21 ++
 rtl/rf_wb_fifo.sv | 51 +++++
 rtl/rf_wb_queue.sv | 61 ++++++
 tb/tb_rf_wb_queue.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: register-file geometry and the writeback entry type shared by the writeback queue.
package mips_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: producer handshakes, register-file write port and forwarding probes of the writeback queue.
interface rf_wb_queue_if import mips_pkg::*; #(parameter int DEPTH = 4, parameter int AW = REG_AW, parameter int DW = XLEN);
    logic                   mem_valid, mem_ready, alu_valid, alu_ready;
    logic [AW-1:0]          mem_addr, alu_addr;
    logic [DW-1:0]          mem_data, alu_data;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;
    logic [AW-1:0]          fwd_raddr1, fwd_raddr2;
    logic                   fwd_hit1, fwd_hit2;
    logic [DW-1:0]          fwd_data1, fwd_data2;
    logic [$clog2(DEPTH):0] wbq_count;
    modport slave (
        input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, fwd_raddr1, fwd_raddr2,
        output mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, wbq_count
    );
    modport master (
        output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, fwd_raddr1, fwd_raddr2,
        input  mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, wbq_count
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: writeback entry FIFO; with RF_WB_QUEUE_FWD_EN it also exposes an oldest-first entry/occupancy view.
module rf_wb_fifo import mips_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  wb_entry_t                 wr_entry,
    output wb_entry_t                 head,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count
`ifdef RF_WB_QUEUE_FWD_EN
    ,
    output wb_entry_t [DEPTH-1:0]     entries,
    output logic [DEPTH-1:0]          occ
`endif
);
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end
`ifdef RF_WB_QUEUE_FWD_EN
    // index 0 is the head, so a higher index is always a younger write
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign entries[i] = mem[rd_ptr + PW'(i)];
        assign occ[i] = CW'(i) < count;
    end
`endif
endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: arbitrates mem/alu writebacks into a FIFO retiring one register write per cycle.
// Forwarding probes are built only when RF_WB_QUEUE_FWD_EN is defined; otherwise they read as 0.
module rf_wb_queue import mips_pkg::*; #(parameter int DEPTH = 4) (
    input  logic         clk,
    input  logic         rst_n,
    rf_wb_queue_if.slave bus
);
    logic full, empty, push;
    wb_entry_t in_entry, head;
`ifdef RF_WB_QUEUE_FWD_EN
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0] occ;
`endif
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;
    // mem always wins, so the selected producer is accepted exactly when the queue has room
    assign in_entry = bus.mem_valid ? {bus.mem_addr, bus.mem_data} : {bus.alu_addr, bus.alu_data};
    assign push = (bus.mem_valid || bus.alu_valid) && !full && in_entry.addr != REG_ZERO;
    assign bus.rf_we = !empty;
    assign bus.rf_waddr = empty ? REG_ZERO : head.addr;
    assign bus.rf_wdata = empty ? '0 : head.data;
    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(!empty),
        .wr_entry(in_entry),
        .head(head),
        .full(full),
        .empty(empty),
        .count(bus.wbq_count)
`ifdef RF_WB_QUEUE_FWD_EN
        ,
        .entries(entries),
        .occ(occ)
`endif
    );
`ifdef RF_WB_QUEUE_FWD_EN
    always_comb begin
        bus.fwd_hit1 = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_hit2 = 1'b0;
        bus.fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && bus.fwd_raddr1 != REG_ZERO && entries[i].addr == bus.fwd_raddr1) begin
                bus.fwd_hit1 = 1'b1;
                bus.fwd_data1 = entries[i].data;
            end
            if (occ[i] && bus.fwd_raddr2 != REG_ZERO && entries[i].addr == bus.fwd_raddr2) begin
                bus.fwd_hit2 = 1'b1;
                bus.fwd_data2 = entries[i].data;
            end
        end
    end
`else
    assign bus.fwd_hit1 = 1'b0;
    assign bus.fwd_hit2 = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: randomized bench for rf_wb_queue against a queue-based model and a modelled register file.
module tb_rf_wb_queue;
    import mips_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rf_wb_queue_if #(.DEPTH(DEPTH), .AW(REG_AW), .DW(XLEN)) bus();
    rf_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
    ent_t q[$];
    logic [31:0] tb_rf [32] = '{default: 32'h0};
    logic [31:0] model_rf [32] = '{default: 32'h0};
    int checks = 0;
    int passes = 0;
    logic acc_m, acc_a;
    always @(posedge clk) if (bus.rf_we) tb_rf[bus.rf_waddr] <= bus.rf_wdata;

    function automatic logic [108:0] obs();
        return {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wbq_count, bus.mem_ready, bus.alu_ready,
                bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2};
    endfunction

    function automatic logic [108:0] expv();
        logic h1, h2;
        logic [31:0] d1, d2, wd;
        logic [4:0] wa;
        h1 = 0; h2 = 0; d1 = 0; d2 = 0; wa = 0; wd = 0;
        if (q.size() > 0) begin
            wa = q[0].a;
            wd = q[0].d;
        end
`ifdef RF_WB_QUEUE_FWD_EN
        foreach (q[i]) begin
            if (bus.fwd_raddr1 != 0 && q[i].a == bus.fwd_raddr1) begin h1 = 1; d1 = q[i].d; end
            if (bus.fwd_raddr2 != 0 && q[i].a == bus.fwd_raddr2) begin h2 = 1; d2 = q[i].d; end
        end
`endif
        return {q.size() > 0, wa, wd, 3'(q.size()), q.size() < DEPTH, q.size() < DEPTH && !bus.mem_valid, h1, d1, h2, d2};
    endfunction

    task automatic model_step();
        acc_m = 0;
        acc_a = 0;
        if (!rst_n) q.delete();
        else begin
            acc_m = bus.mem_valid && q.size() < DEPTH;
            acc_a = bus.alu_valid && q.size() < DEPTH && !bus.mem_valid;
            if (q.size() > 0) begin
                model_rf[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (acc_m && bus.mem_addr != 0) q.push_back('{bus.mem_addr, bus.mem_data});
            else if (acc_a && bus.alu_addr != 0) q.push_back('{bus.alu_addr, bus.alu_data});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid = v; bus.mem_addr = a; bus.mem_data = d;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_addr = a; bus.alu_data = d;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_mem(1, 5, 32'h1234_5678);
        set_alu(0, 0, 0);
        bus.fwd_raddr1 = 0;
        bus.fwd_raddr2 = 0;
        q.delete();
        #12;
        checks++; if (obs() !== expv()) $display("FAIL reset: got %h exp %h", obs(), expv()); else passes++;
        checks++; if ({bus.rf_we, bus.wbq_count, bus.mem_ready} !== 5'b0_000_1) $display("FAIL reset_core: got %b exp 00001", {bus.rf_we, bus.wbq_count, bus.mem_ready}); else passes++;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (obs() !== expv()) $display("FAIL reset_release: got %h exp %h", obs(), expv()); else passes++;
        tick();
        set_mem(0, 0, 0);
        #1;
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) $display("FAIL first_retire: got %h exp %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd5, 32'h1234_5678}); else passes++;
        tick();
        checks++; if (tb_rf[5] !== 32'h1234_5678) $display("FAIL r5_written: got %h exp 12345678", tb_rf[5]); else passes++;
    endtask

    task automatic test_arbitration();
        set_mem(1, 3, 32'hAAAA_0000);
        set_alu(1, 4, 32'h0000_BBBB);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (obs() !== expv()) $display("FAIL arb cyc %0d: got %h exp %h", i, obs(), expv()); else passes++;
            tick();
            if (i == 0) set_mem(0, 0, 0);
            if (i == 1) set_alu(0, 0, 0);
        end
        checks++; if ({tb_rf[3], tb_rf[4]} !== {32'hAAAA_0000, 32'h0000_BBBB}) $display("FAIL arb_order: got %h %h exp aaaa0000 0000bbbb", tb_rf[3], tb_rf[4]); else passes++;
    endtask

    task automatic test_zero_reg();
        set_alu(1, 0, 32'hDEAD_BEEF);
        #1;
        checks++; if (obs() !== expv()) $display("FAIL zero_accept: got %h exp %h", obs(), expv()); else passes++;
        tick();
        set_alu(0, 0, 0);
        #1;
        checks++; if ({bus.rf_we, bus.wbq_count} !== 4'b0) $display("FAIL zero_not_queued: got %b exp 0000", {bus.rf_we, bus.wbq_count}); else passes++;
        tick();
        checks++; if (tb_rf[0] !== 32'h0) $display("FAIL zero_reg: got %h exp 0", tb_rf[0]); else passes++;
    endtask

    task automatic test_forward();
        bus.fwd_raddr1 = 7;
        bus.fwd_raddr2 = 0;
        set_mem(1, 7, 32'h11);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (obs() !== expv()) $display("FAIL fwd cyc %0d: got %h exp %h", i, obs(), expv()); else passes++;
            tick();
            if (i == 0) set_mem(1, 7, 32'h22);
            else set_mem(0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        bus.fwd_raddr1 = 3;
        bus.fwd_raddr2 = 6;
        for (int i = 0; i < 18; i++) begin
            if (i < 16 && i % 2 == 0) begin set_mem(1, 5'(i % 8 + 1), $urandom); set_alu(0, 0, 0); end
            else if (i < 16) begin set_alu(1, 5'(i % 8 + 1), $urandom); set_mem(0, 0, 0); end
            else begin set_mem(0, 0, 0); set_alu(0, 0, 0); end
            #1;
            checks++; if (obs() !== expv()) $display("FAIL b2b cyc %0d: got %h exp %h", i, obs(), expv()); else passes++;
            if (bus.rf_we === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 16) $display("FAIL b2b_pulses: got %0d exp 16", pulses); else passes++;
    endtask

    task automatic test_random();
        set_mem(0, 0, 0);
        set_alu(0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            if (!bus.mem_valid || acc_m) set_mem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
            if (!bus.alu_valid || acc_a) set_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
            bus.fwd_raddr1 = 5'($urandom_range(0, 9));
            bus.fwd_raddr2 = 5'($urandom_range(0, 9));
            #1;
            checks++; if (obs() !== expv()) $display("FAIL rand cyc %0d: got %h exp %h", i, obs(), expv()); else passes++;
            tick();
        end
        set_mem(0, 0, 0);
        set_alu(0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic same;
        set_mem(1, 9, 32'h55);
        tick();
        set_mem(0, 0, 0);
        #1;
        checks++; if (bus.rf_we !== 1'b1) $display("FAIL mid_inflight: got %b exp 1", bus.rf_we); else passes++;
        rst_n = 0;
        q.delete();
        #1;
        checks++; if (obs() !== expv()) $display("FAIL mid_reset: got %h exp %h", obs(), expv()); else passes++;
        @(posedge clk);
        #2;
        checks++; if (tb_rf[9] !== model_rf[9]) $display("FAIL mid_r9: got %h exp %h", tb_rf[9], model_rf[9]); else passes++;
        same = 1;
        for (int r = 0; r < 32; r++) if (tb_rf[r] !== model_rf[r]) same = 0;
        checks++; if (same !== 1'b1) $display("FAIL regfile_contents: got mismatching registers exp all equal"); else passes++;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (obs() !== expv()) $display("FAIL mid_release: got %h exp %h", obs(), expv()); else passes++;
    endtask

    initial begin
        acc_m = 0;
        acc_a = 0;
        test_reset();
        test_arbitration();
        test_zero_reg();
        test_forward();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
